// File: rtl/exu_mdu_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: M-extension funct3 codes and FSM states.
// Optional divider is controlled by the MDU_DIV_EN macro (left undefined by default).
package exu_mdu_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    // funct3[2] separates div/rem from mul; funct3[0] marks the unsigned variants; funct3[1] selects rem
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_div(input logic [2:0] op);
        return !op[0];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/exu_div_iter.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per enabled cycle.
// Only instantiated when MDU_DIV_EN is defined.
module exu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            enable,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;

    // quotient/remainder are this iteration's results; on the done cycle they are final
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
            quotient  = {quo_q[XLEN-2:0], 1'b1};
            remainder = diff[XLEN-1:0];
        end else begin
            quotient  = {quo_q[XLEN-2:0], 1'b0};
            remainder = rem_shift[XLEN-1:0];
        end
        done = enable && (count == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(XLEN - 1);
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (enable) begin
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end

endmodule

// File: rtl/exu_mdu.sv
// EX-stage multi-cycle multiply/divide unit (RV M-extension) with request/response handshakes.
// Define MDU_DIV_EN to compile in the iterative divider; otherwise div/rem return zero.
module exu_mdu
    import exu_mdu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [2:0]                req_op_i,
    input  logic [XLEN-1:0]           req_op1_i,
    input  logic [XLEN-1:0]           req_op2_i,
    input  logic [REG_ADDR_WIDTH-1:0] req_waddr_i,
    input  logic                      flush_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [XLEN-1:0]           resp_data_o,
    output logic [REG_ADDR_WIDTH-1:0] resp_waddr_o,
    output logic                      busy_o
);

    mdu_state_e state;
    mdu_state_e state_next;

    logic                      accept;
    logic [2:0]                op_q;
    logic [XLEN-1:0]           op1_q;
    logic [XLEN-1:0]           op2_q;
    logic [REG_ADDR_WIDTH-1:0] waddr_q;

    logic                      load_resp;
    logic [XLEN-1:0]           resp_next;
    logic [REG_ADDR_WIDTH-1:0] waddr_next;

    logic signed [XLEN:0]      mul_a;
    logic signed [XLEN:0]      mul_b;
    logic signed [2*XLEN-1:0]  product;
    logic [XLEN-1:0]           mul_result;

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] value, input logic neg);
        return neg ? -value : value;
    endfunction

    assign req_ready_o  = (state == MDU_IDLE) && !flush_i;
    assign accept       = req_valid_i && req_ready_o;
    assign busy_o       = (state != MDU_IDLE);
    assign resp_valid_o = (state == MDU_DONE);

    // Operands are extended to XLEN+1 bits so one signed multiplier serves all four mul ops;
    // only the low 2*XLEN product bits are ever selected.
    always_comb begin
        mul_a      = {(op_q != INST_MULHU) & op1_q[XLEN-1], op1_q};
        mul_b      = {((op_q == INST_MUL) || (op_q == INST_MULH)) & op2_q[XLEN-1], op2_q};
        product    = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
        mul_result = (op_q == INST_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

`ifdef MDU_DIV_EN
    logic            div_signed;
    logic            div_rem;
    logic            op1_neg;
    logic            op2_neg;
    logic            div_by_zero;
    logic            div_overflow;
    logic            div_special;
    logic [XLEN-1:0] op1_mag;
    logic [XLEN-1:0] op2_mag;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] div_quotient;
    logic [XLEN-1:0] div_remainder;
    logic [XLEN-1:0] div_result;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            rem_sel_q;
    logic            div_start;
    logic            div_done;

    // Special cases are resolved straight from the request so they never enter the iterator
    always_comb begin
        div_signed   = is_signed_div(req_op_i);
        div_rem      = is_rem_op(req_op_i);
        op1_neg      = div_signed && req_op1_i[XLEN-1];
        op2_neg      = div_signed && req_op2_i[XLEN-1];
        op1_mag      = apply_sign(req_op1_i, op1_neg);
        op2_mag      = apply_sign(req_op2_i, op2_neg);
        div_by_zero  = (req_op2_i == '0);
        div_overflow = div_signed && (req_op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&req_op2_i);
        div_special  = div_by_zero || div_overflow;
        if (div_by_zero) begin
            special_result = div_rem ? req_op1_i : '1;
        end else begin
            special_result = div_rem ? '0 : req_op1_i;
        end
        div_result = rem_sel_q ? apply_sign(div_remainder, neg_rem_q)
                               : apply_sign(div_quotient, neg_quo_q);
    end

    assign div_start = accept && is_div_op(req_op_i) && !div_special;

    exu_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .enable   (state == MDU_DIV),
        .dividend (op1_mag),
        .divisor  (op2_mag),
        .done     (div_done),
        .quotient (div_quotient),
        .remainder(div_remainder)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            neg_quo_q <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            rem_sel_q <= div_rem;
        end
    end
`endif

    always_comb begin
        state_next = state;
        load_resp  = 1'b0;
        resp_next  = '0;
        waddr_next = waddr_q;
        case (state)
            MDU_IDLE: begin
                if (accept) begin
                    waddr_next = req_waddr_i;
                    if (!is_div_op(req_op_i)) begin
                        state_next = MDU_MUL;
                    end else begin
`ifdef MDU_DIV_EN
                        if (div_special) begin
                            state_next = MDU_DONE;
                            load_resp  = 1'b1;
                            resp_next  = special_result;
                        end else begin
                            state_next = MDU_DIV;
                        end
`else
                        state_next = MDU_DONE;
                        load_resp  = 1'b1;
`endif
                    end
                end
            end
            MDU_MUL: begin
                state_next = MDU_DONE;
                load_resp  = 1'b1;
                resp_next  = mul_result;
            end
            MDU_DIV: begin
`ifdef MDU_DIV_EN
                if (div_done) begin
                    state_next = MDU_DONE;
                    load_resp  = 1'b1;
                    resp_next  = div_result;
                end
`else
                state_next = MDU_IDLE;
`endif
            end
            MDU_DONE: begin
                if (resp_ready_i) begin
                    state_next = MDU_IDLE;
                end
            end
            default: state_next = MDU_IDLE;
        endcase
        // flush wins over both handshakes and discards any result being produced
        if (flush_i) begin
            state_next = MDU_IDLE;
            load_resp  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_o  <= '0;
            resp_waddr_o <= '0;
        end else if (load_resp) begin
            resp_data_o  <= resp_next;
            resp_waddr_o <= waddr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= req_op_i;
            op1_q   <= req_op1_i;
            op2_q   <= req_op2_i;
            waddr_q <= req_waddr_i;
        end
    end

endmodule

// File: tb/tb_exu_mdu.sv
// Self-checking bench for exu_mdu: behavioural result/latency model, per-cycle compare, directed and random traffic.
// Expectations follow MDU_DIV_EN when it is defined for the build.
module tb_exu_mdu;

    localparam int XLEN = 32;
    localparam int AW   = 5;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = '0;
    logic [XLEN-1:0] req_op1 = '0;
    logic [XLEN-1:0] req_op2 = '0;
    logic [AW-1:0]   req_waddr = '0;
    logic            flush = 1'b0;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [AW-1:0]   resp_waddr;
    logic            busy;

    logic rr_dir  = 1'b1;
    logic rand_bp = 1'b0;
    logic bp_rand = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign resp_ready = rand_bp ? bp_rand : rr_dir;

    always @(posedge clk) begin
        #1;
        bp_rand <= ($urandom_range(0, 3) != 0);
    end

    exu_mdu #(
        .XLEN(XLEN),
        .REG_ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_op1_i   (req_op1),
        .req_op2_i   (req_op2),
        .req_waddr_i (req_waddr),
        .flush_i     (flush),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_data_o (resp_data),
        .resp_waddr_o(resp_waddr),
        .busy_o      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from the RV M-extension definitions, using 64-bit arithmetic
    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
            OP_MULHSU: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
            OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            OP_DIV: begin
                if (!DIV_EN) return 32'h0;
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = longint'($signed(a)) / longint'($signed(b));
                return sp[31:0];
            end
            OP_DIVU: begin
                if (!DIV_EN) return 32'h0;
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            OP_REM: begin
                if (!DIV_EN) return 32'h0;
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = longint'($signed(a)) % longint'($signed(b));
                return sp[31:0];
            end
            default: begin
                if (!DIV_EN) return 32'h0;
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from acceptance to the first cycle with resp_valid high
    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
        if (!DIV_EN) return 1;
        if (b == 0) return 1;
        if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Per-cycle compare: model phase 0 = idle, 1 = computing (countdown), 2 = result pending
    initial begin : compare
        int          m_phase;
        int          m_cnt;
        logic [31:0] m_data;
        logic [4:0]  m_waddr;
        m_phase = 0;
        m_cnt   = 0;
        m_data  = '0;
        m_waddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_phase = 0;
            end else begin
                chk_bit("cyc_req_ready", req_ready, (m_phase == 0) && !flush);
                chk_bit("cyc_resp_valid", resp_valid, m_phase == 2);
                chk_bit("cyc_busy", busy, m_phase != 0);
                if (m_phase == 2) begin
                    chk("cyc_resp_data", resp_data, m_data);
                    chk("cyc_resp_waddr", 32'(resp_waddr), 32'(m_waddr));
                end
                if (flush) begin
                    m_phase = 0;
                end else begin
                    case (m_phase)
                        0: if (req_valid) begin
                            m_data  = model_res(req_op, req_op1, req_op2);
                            m_waddr = req_waddr;
                            m_cnt   = model_lat(req_op, req_op1, req_op2) - 1;
                            m_phase = (m_cnt == 0) ? 2 : 1;
                        end
                        1: begin
                            m_cnt--;
                            if (m_cnt == 0) m_phase = 2;
                        end
                        default: if (resp_ready) m_phase = 0;
                    endcase
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] w);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        req_waddr = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_timeout: req_ready stayed 0, expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] w, input logic [31:0] lit, input int lit_lat, input int hold);
        int          lat;
        bit          got;
        logic [31:0] d;
        chk({name, "_model"}, model_res(op, a, b), lit);
        chk({name, "_model_lat"}, model_lat(op, a, b), lit_lat);
        if (hold > 0) rr_dir = 1'b0;
        issue(op, a, b, w);
        lat = 0;
        got = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: resp_valid stayed 0, expected 1 within 100 cycles", name);
        end
        d = resp_data;
        chk({name, "_latency"}, lat, lit_lat);
        chk({name, "_data"}, d, lit);
        chk({name, "_waddr"}, 32'(resp_waddr), 32'(w));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk_bit({name, "_hold_valid"}, resp_valid, 1'b1);
                chk({name, "_hold_data"}, resp_data, lit);
                chk({name, "_hold_waddr"}, 32'(resp_waddr), 32'(w));
            end
            @(posedge clk);
            #1 rr_dir = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          idle;

        #1;
        chk_bit("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_waddr", 32'(resp_waddr), 32'h0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_req_ready", req_ready, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mulh_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 2, 0);
        run_op("mulhu_m1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2, 0);
        run_op("mul_m1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 2, 0);
        run_op("mulhsu_m1x2", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 32'hFFFF_FFFF, 2, 0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 33 : 1, 0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 33 : 1, 0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd7, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1, 0);
        run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd8, DIV_EN ? 32'd5 : 32'h0, 1, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, DIV_EN ? 32'h8000_0000 : 32'h0, 1, 0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 1, 0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd11, DIV_EN ? 32'd14 : 32'h0, DIV_EN ? 33 : 1, 0);

        run_op("mul_bp", OP_MUL, 32'd3, 32'd5, 5'd12, 32'd15, 2, 10);

        // flush during the tenth divide iteration, then a fresh multiply
        rr_dir = 1'b0;
        issue(OP_DIV, 32'd100, 32'd7, 5'd13);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk_bit("flush_resp_valid", resp_valid, 1'b0);
        chk_bit("flush_busy", busy, 1'b0);
        @(posedge clk);
        #1 rr_dir = 1'b1;
        run_op("mulhu_after_flush", OP_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd14, 32'h0000_0001, 2, 0);

        // asynchronous reset in the middle of a divide
        issue(OP_DIV, 32'd1000, 32'd3, 5'd15);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_bit("midrst_resp_valid", resp_valid, 1'b0);
        chk("midrst_resp_data", resp_data, 32'h0);
        chk("midrst_resp_waddr", 32'(resp_waddr), 32'h0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_req_ready", req_ready, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk_bit("postrst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;

        // random traffic with random backpressure and occasional flushes
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: begin a = $urandom; b = 32'h0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = $urandom_range(0, 40);
                    b = $urandom_range(1, 6);
                    if ($urandom_range(0, 1) != 0) a = -a;
                    if ($urandom_range(0, 1) != 0) b = -b;
                end
                default: begin a = $urandom; b = $urandom; end
            endcase
            issue(op, a, b, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        end
        rand_bp = 1'b0;
        rr_dir  = 1'b1;
        idle    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk_bit("final_idle", idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_mdu.md
# exu_mdu

Parametrised multi-cycle multiply/divide unit for the EX stage, implementing the full RV M-extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It replaces the single-cycle combinational multiply path in the ALU with a registered multiplier and an iterative restoring divider. It uses a valid/ready request handshake and a valid/ready response handshake. The EX stage stalls on `req_ready_o`/`busy_o` and writes back `resp_data_o` to `resp_waddr_o` on response handshake.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- REG_ADDR_WIDTH, 5: destination register index width.
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  unit can accept (state IDLE and no flush).
- req_op_i  input  3  funct3 of the M instruction (`INST_MUL`..`INST_REMU` encodings).
- req_op1_i  input  XLEN  rs1 value.
- req_op2_i  input  XLEN  rs2 value.
- req_waddr_i  input  REG_ADDR_WIDTH  rd.
- flush_i  input  1  kill in-flight operation (interrupt/branch flush).
- resp_valid_o  output  1  result available.
- resp_ready_i  input  1  writeback accepts result.
- resp_data_o  output  XLEN  result.
- resp_waddr_o  output  REG_ADDR_WIDTH  rd of the result.
- busy_o  output  1  state ≠ IDLE.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: on req_valid_i & req_ready_o, latch op, operands and waddr.
  - Mul ops go to MUL.
  - Div/rem ops go to DIV, except special cases, which go directly to DONE.
- MUL: one cycle.
  - Form a signed (XLEN+1)×(XLEN+1) product. rs1 is sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU. rs2 is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
  - MUL returns product[XLEN-1:0]; the other ops return product[2·XLEN-1:XLEN]. Go to DONE.
- DIV: XLEN iterations of restoring division on magnitudes. Signed ops negate negative operands at entry. Counter runs XLEN-1 down to 0. On the last iteration:
  - Apply sign correction: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Select quotient or remainder, then go to DONE.
- Special cases (resolved in IDLE, no iteration):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1): DIV returns rs1; REM returns 0.
- DONE: resp_valid_o = 1 with stable data/waddr until resp_ready_i. On handshake go to IDLE. There is no acceptance in the same cycle as the response handshake.
- flush_i (any state): next state IDLE. resp_valid_o drops next cycle. flush_i has priority over both handshakes, and req_ready_o is forced 0 while flush_i = 1.
- Unknown req_op_i values cannot occur (3-bit funct3 fully decoded).

## Timing
- Reset values: state IDLE, resp_valid_o = 0, resp_data_o = 0, resp_waddr_o = 0, busy_o = 0, req_ready_o = 1 (when flush_i = 0).
- Acceptance in cycle T gives resp_valid_o at the following cycle:
  - MUL family: T+2.
  - Div normal: T+1+XLEN (T+33 for XLEN = 32).
  - Div special case: T+1.
- Back-to-back: next acceptance no earlier than the cycle after the response handshake.
- Response backpressure: DONE holds indefinitely. Outputs must not change while resp_valid_o = 1 and resp_ready_i = 0.
- Reset mid-operation: immediate return to reset values; the in-flight result is lost.

## Configuration
- `MDU_DIV_EN` defined: divider, special-case logic and DIV state are compiled in; full M-extension behaviour as above.
- `MDU_DIV_EN` undefined: divider is removed. Div/rem requests are accepted and complete at T+1 with resp_data_o = 0. Mul behaviour and timing are unchanged.

## Structure
- Shared defines (existing `defines.v`): M funct3 encodings (`INST_MUL`..`INST_REMU`), `ZeroWord`.
- New shared constants belong there too: MDU state encoding and the `MDU_DIV_EN` macro default.
- Sub-module `exu_div_iter`:
  - Parametrised by XLEN.
  - Inputs: start, magnitudes; output: done pulse.
  - Holds the quotient/remainder shift registers and the iteration counter.
  - Instantiated only under `MDU_DIV_EN`.
- Top level holds the FSM, the multiplier, sign handling and the response registers.

## Test plan
- MULH rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF → 0x00000000 at T+2. MULHU with the same operands → 0xFFFFFFFE. MUL → 0x00000001.
- DIV rs1 = −7 (0xFFFFFFF9), rs2 = 2 → 0xFFFFFFFD at T+33. REM with the same operands → 0xFFFFFFFF.
- DIVU rs1 = 5, rs2 = 0 → 0xFFFFFFFF at T+1. REMU with the same operands → 5. DIV rs1 = 0x80000000, rs2 = 0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: resp_ready_i held 0 for 10 cycles after MUL completes → resp_valid_o, data and waddr stable. req_ready_o = 0 throughout; single handshake on release.
- flush_i asserted at iteration 10 of a DIV → IDLE next cycle, no resp_valid_o pulse. A new MULHU 0x10000 × 0x10000 accepted afterwards returns 0x00000001.
- rst asserted mid-DIV, asynchronous to clk → all outputs at reset values immediately; req_ready_o = 1 after release.
